// File: rtl/sensor_pkg.sv
// Shared types, limits and the sensor error rule for the sensor scan controller.
package sensor_pkg;

    localparam int unsigned MAX_GROUPS   = 16;
    localparam int unsigned MAX_DEBOUNCE = 15;
    localparam int unsigned CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ALERT
    } scan_state_t;

    function automatic logic sensor_err(input logic [3:0] s);
        return s[0] | (s[1] & s[2]) | (s[1] & s[3]);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One saturating debounce counter; fault_hit marks the evaluation that reaches DEBOUNCE.
module sensor_debounce
    import sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic eval,
    input  logic err,
    output logic fault_hit
);

    localparam logic [CNT_W-1:0] Limit   = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] LimitM1 = CNT_W'(DEBOUNCE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (eval) begin
            if (!err) begin
                cnt_d = '0;
            end else if (cnt_q != Limit) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Only the transition into saturation counts; a saturated group stays silent.
    assign fault_hit = eval & err & ~clear & (cnt_q == LimitM1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Round-robin sensor group scanner with debounce, sticky faults and ack-cleared irq.
// Optional macro SENSOR_FAULT_CAPTURE_EN adds first-fault capture outputs first_grp/first_snap.
module sensor_scan_ctrl
    import sensor_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = 4,
    parameter int unsigned DEBOUNCE   = 3,
    localparam int unsigned GW = (NUM_GROUPS > 2) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    enable,
    input  logic                    scan_tick,
    input  logic [4*NUM_GROUPS-1:0] sensors,
    input  logic [NUM_GROUPS-1:0]   mask,
    input  logic                    ack,
    output logic [GW-1:0]           grp_sel,
    output logic [NUM_GROUPS-1:0]   fault_vec,
    output logic                    irq,
    output logic                    busy
`ifdef SENSOR_FAULT_CAPTURE_EN
    ,
    output logic [GW-1:0]           first_grp,
    output logic [3:0]              first_snap
`endif
);

    scan_state_t state_q, state_d;
    logic [GW-1:0] sel_q, sel_d;
    logic [NUM_GROUPS-1:0] fault_q, fault_d, err, hit, eval_g;
    logic irq_q, eval, new_fault, ack_alert;

    assign eval      = (state_q != IDLE) & enable & scan_tick;
    assign new_fault = |hit;
    assign ack_alert = ack & (state_q == ALERT);

    always_comb begin
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            err[g]    = sensor_err(sensors[4*g +: 4]) & ~mask[g];
            eval_g[g] = eval & (sel_q == GW'(g));
        end
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_deb
        sensor_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_deb (
            .clk      (clk),
            .n_rst    (n_rst),
            .clear    (~enable),
            .eval     (eval_g[g]),
            .err      (err[g]),
            .fault_hit(hit[g])
        );
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (enable) state_d = SCAN;
            SCAN: begin
                if (new_fault) state_d = ALERT;
                else if (!enable) state_d = IDLE;
            end
            ALERT: if (ack && !new_fault) state_d = enable ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // A fault latching alongside ack wins over the clear.
    always_comb begin
        fault_d = ack_alert ? hit : (fault_q | hit);
        sel_d   = sel_q;
        if (!enable) begin
            sel_d = '0;
        end else if (eval) begin
            sel_d = (sel_q == GW'(NUM_GROUPS - 1)) ? '0 : sel_q + GW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sel_q   <= '0;
            fault_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            fault_q <= fault_d;
            irq_q   <= (state_d == ALERT);
        end
    end

    assign grp_sel   = sel_q;
    assign fault_vec = fault_q;
    assign irq       = irq_q;

`ifdef SENSOR_FAULT_CAPTURE_EN
    logic [GW-1:0] cap_grp_q, cap_grp_d;
    logic [3:0]    cap_snap_q, cap_snap_d;

    always_comb begin
        cap_grp_d  = cap_grp_q;
        cap_snap_d = cap_snap_q;
        if (new_fault && (fault_q == '0 || ack_alert)) begin
            // Walk downwards so the lowest latching index is the one kept.
            for (int unsigned g = NUM_GROUPS; g > 0; g--) begin
                if (hit[g-1]) begin
                    cap_grp_d  = GW'(g - 1);
                    cap_snap_d = sensors[4*(g-1) +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cap_grp_q  <= '0;
            cap_snap_q <= '0;
        end else begin
            cap_grp_q  <= cap_grp_d;
            cap_snap_q <= cap_snap_d;
        end
    end

    assign first_grp  = cap_grp_q;
    assign first_snap = cap_snap_q;
`endif

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Randomized and directed bench for sensor_scan_ctrl against a behavioural scan model.
module tb_sensor_scan_ctrl;

    localparam int N   = 4;
    localparam int DEB = 3;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         enable;
    logic         scan_tick;
    logic [4*N-1:0] sensors;
    logic [N-1:0] mask;
    logic         ack;
    logic [1:0]   grp_sel;
    logic [N-1:0] fault_vec;
    logic         irq;
    logic         busy;
`ifdef SENSOR_FAULT_CAPTURE_EN
    logic [1:0]   first_grp;
    logic [3:0]   first_snap;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // Model state: "on" means scanning or alerting; alerting is simply "any fault pending".
    bit         m_on;
    int         m_sel;
    int         m_cnt[N];
    bit [N-1:0] m_fv;
    int         m_fg;
    bit [3:0]   m_fs;

    sensor_scan_ctrl #(
        .NUM_GROUPS(N),
        .DEBOUNCE  (DEB)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .enable    (enable),
        .scan_tick (scan_tick),
        .sensors   (sensors),
        .mask      (mask),
        .ack       (ack),
        .grp_sel   (grp_sel),
        .fault_vec (fault_vec),
        .irq       (irq),
        .busy      (busy)
`ifdef SENSOR_FAULT_CAPTURE_EN
        ,
        .first_grp (first_grp),
        .first_snap(first_snap)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rule(input logic [3:0] s);
        return s[0] || (s[1] && (s[2] || s[3]));
    endfunction

    function automatic logic [4*N-1:0] pack(input logic [3:0] g0, input logic [3:0] g1,
                                            input logic [3:0] g2, input logic [3:0] g3);
        return {g3, g2, g1, g0};
    endfunction

    task automatic model_reset();
        m_on = 0; m_sel = 0; m_fv = '0; m_fg = 0; m_fs = '0;
        for (int g = 0; g < N; g++) m_cnt[g] = 0;
    endtask

    task automatic model_step();
        bit [N-1:0] hit;
        bit         alert;
        hit   = '0;
        alert = (m_fv != 0);
        if (enable && scan_tick && m_on) begin
            if (rule(sensors[4*m_sel +: 4]) && !mask[m_sel]) begin
                if (m_cnt[m_sel] == DEB - 1) hit[m_sel] = 1'b1;
                if (m_cnt[m_sel] < DEB) m_cnt[m_sel]++;
            end else begin
                m_cnt[m_sel] = 0;
            end
            m_sel = (m_sel + 1) % N;
        end
        if (!enable) begin
            m_sel = 0;
            for (int g = 0; g < N; g++) m_cnt[g] = 0;
        end
        if (hit != 0 && (!alert || ack)) begin
            for (int g = N - 1; g >= 0; g--) begin
                if (hit[g]) begin
                    m_fg = g;
                    m_fs = sensors[4*g +: 4];
                end
            end
        end
        if (!m_on) m_on = enable;
        else if (alert) m_on = !(ack && hit == 0 && !enable);
        else m_on = enable;
        m_fv = (alert && ack) ? hit : (m_fv | hit);
    endtask

    task automatic compare_all();
        check_val("grp_sel", 32'(grp_sel), 32'(m_sel));
        check_val("fault_vec", 32'(fault_vec), 32'(m_fv));
        check_val("irq", 32'(irq), 32'(m_fv != 0));
        check_val("busy", 32'(busy), 32'(m_on));
`ifdef SENSOR_FAULT_CAPTURE_EN
        check_val("first_grp", 32'(first_grp), 32'(m_fg));
        check_val("first_snap", 32'(first_snap), 32'(m_fs));
`endif
    endtask

    task automatic step(input logic en, input logic tk, input logic [4*N-1:0] s,
                        input logic [N-1:0] m, input logic ak);
        enable = en; scan_tick = tk; sensors = s; mask = m; ack = ak;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_grp_sel"}, 32'(grp_sel), 32'd0);
        check_val({tag, "_fault_vec"}, 32'(fault_vec), 32'd0);
        check_val({tag, "_irq"}, 32'(irq), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [4*N-1:0] s;
        logic [N-1:0]   m;

        // Reset held with random inputs.
        n_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            enable = 1'($urandom); scan_tick = 1'($urandom); sensors = 16'($urandom);
            mask = 4'($urandom); ack = 1'($urandom);
            @(posedge clk);
        end
        #1;
        check_zero("reset");
        n_rst = 1'b1;
        step(1, 0, '0, '0, 0);
        check_val("busy_after_enable", 32'(busy), 32'd1);

        // Debounce latch: group 2 errors, evaluated on ticks 3, 7, 11.
        s = pack(4'h0, 4'h0, 4'b0110, 4'h0);
        for (int t = 1; t <= 10; t++) step(1, 1, s, '0, 0);
        check_val("latch_not_early", 32'(fault_vec), 32'd0);
        step(1, 1, s, '0, 0);
        check_val("latch_vec", 32'(fault_vec), 32'b0100);
        check_val("latch_irq", 32'(irq), 32'd1);

        // Ack collision: group 3 reaches its third error on the ack cycle (tick 20).
        s = pack(4'h0, 4'h0, 4'h0, 4'b1010);
        for (int t = 12; t <= 19; t++) step(1, 1, s, '0, 0);
        step(1, 1, s, '0, 1);
        check_val("collide_vec", 32'(fault_vec), 32'b1000);
        check_val("collide_irq", 32'(irq), 32'd1);
        step(1, 0, '0, '0, 1);
        check_val("ack_vec", 32'(fault_vec), 32'd0);
        check_val("ack_irq", 32'(irq), 32'd0);

        // Glitch reject, then a fresh run of three errors.
        for (int t = 0; t < 8; t++) step(1, 1, pack(4'h0, 4'b0001, 4'h0, 4'h0), '0, 0);
        for (int t = 0; t < 4; t++) step(1, 1, pack(4'h0, 4'b1000, 4'h0, 4'h0), '0, 0);
        for (int t = 0; t < 8; t++) step(1, 1, pack(4'h0, 4'b0001, 4'h0, 4'h0), '0, 0);
        check_val("glitch_none", 32'(fault_vec), 32'd0);
        for (int t = 0; t < 4; t++) step(1, 1, pack(4'h0, 4'b0001, 4'h0, 4'h0), '0, 0);
        check_val("glitch_fresh", 32'(fault_vec), 32'b0010);
        step(1, 0, '0, '0, 1);

        // Mask suppresses group 0; unmasking needs three new evaluations.
        s = pack(4'b0001, 4'h0, 4'h0, 4'h0);
        for (int t = 0; t < 20; t++) step(1, 1, s, 4'b0001, 0);
        check_val("mask_none", 32'(fault_vec), 32'd0);
        for (int t = 0; t < 12; t++) step(1, 1, s, 4'b0000, 0);
        check_val("unmask_fault", 32'(fault_vec), 32'b0001);
        step(1, 0, '0, '0, 1);

        // Enable drop mid-scan with grp_sel=2 and nonzero counters.
        step(0, 0, '0, '0, 0);
        step(1, 0, '0, '0, 0);
        s = pack(4'b0001, 4'b0001, 4'h0, 4'h0);
        step(1, 1, s, '0, 0);
        step(1, 1, s, '0, 0);
        check_val("pre_drop_sel", 32'(grp_sel), 32'd2);
        step(0, 1, s, '0, 0);
        check_val("drop_sel", 32'(grp_sel), 32'd0);
        for (int t = 0; t < 6; t++) step(1, 1, s, '0, 0);

        // Asynchronous reset while alerting.
        s = pack(4'b0011, 4'h0, 4'h0, 4'h0);
        for (int t = 0; t < 12; t++) step(1, 1, s, '0, 0);
        check_val("pre_reset_irq", 32'(irq), 32'd1);
        #2 n_rst = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1 n_rst = 1'b1;
        step(0, 0, '0, '0, 0);

        // Randomized traffic with slowly drifting sensors.
        s = '0;
        m = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                int g;
                g = $urandom_range(0, N - 1);
                s[4*g +: 4] = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
            end
            if ($urandom_range(0, 31) == 0) m = 4'($urandom);
            step(($urandom_range(0, 15) != 0), 1'($urandom), s, m,
                 ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
